// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I decode definitions.
//   - opcode constants for the nine supported instruction classes
//   - alu_op_t   : ALU operation handed to the execute stage
//   - imm_type_t : immediate format selected by opcode
//   - ctrl_t     : decoded control bits
//   - imm_type_of / alu_from_funct3 : small decode helpers
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_type_t;

   typedef struct packed {
      logic alusrc;
      logic memread;
      logic memwrite;
      logic regwrite;
      logic memtoreg;
      logic branch;
      logic jump;
      logic illegal;
   } ctrl_t;

   function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: return IMM_I;
         OP_STORE:                 return IMM_S;
         OP_BRANCH:                return IMM_B;
         OP_LUI, OP_AUIPC:         return IMM_U;
         OP_JAL:                   return IMM_J;
         default:                  return IMM_NONE;
      endcase
   endfunction

   // alt selects SUB/SRA; callers decide when instr[30] is meaningful.
   function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
      case (funct3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: ID/EX pipeline register bundle.
//   master : driven by decode_stage (registered outputs)
//   slave  : consumed by the execute stage / forwarding unit
interface decode_stage_if;

   logic                  id_ex_valid;
   logic [31:0]           id_ex_pc;
   logic [31:0]           id_ex_rs1_val;
   logic [31:0]           id_ex_rs2_val;
   logic [31:0]           id_ex_imm;
   logic [4:0]            id_ex_rs1;
   logic [4:0]            id_ex_rs2;
   logic [4:0]            id_ex_rd;
   rv32i_pkg::alu_op_t    id_ex_alu_op;
   logic                  id_ex_alusrc;
   logic                  id_ex_memread;
   logic                  id_ex_memwrite;
   logic                  id_ex_regwrite;
   logic                  id_ex_memtoreg;
   logic                  id_ex_branch;
   logic                  id_ex_jump;
   logic                  id_ex_illegal;
   logic [2:0]            id_ex_funct3;

   modport master (
      output id_ex_valid, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm,
             id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_alu_op, id_ex_alusrc,
             id_ex_memread, id_ex_memwrite, id_ex_regwrite, id_ex_memtoreg,
             id_ex_branch, id_ex_jump, id_ex_illegal, id_ex_funct3
   );

   modport slave (
      input  id_ex_valid, id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm,
             id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_alu_op, id_ex_alusrc,
             id_ex_memread, id_ex_memwrite, id_ex_regwrite, id_ex_memtoreg,
             id_ex_branch, id_ex_jump, id_ex_illegal, id_ex_funct3
   );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
//   instr : 32-bit instruction word
//   imm   : sign-extended immediate (0 for R-type and unknown opcodes)
module imm_gen
   import rv32i_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   always_comb begin
      imm = '0;
      case (imm_type_of(instr[6:0]))
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode plus ID/EX pipeline register.
//   clk, rst                  : clock, synchronous active-high reset
//   if_id_valid/pc/instr      : instruction from IF/ID
//   flush                     : kill the instruction in ID (branch/jump taken in EX)
//   rs1, rs2                  : register file read addresses (combinational)
//   rd1, rd2                  : register file read data (asynchronous)
//   wb_regwrite/rd/wd         : writeback port, bypassed into the read data
//   stall                     : load-use stall, holds PC and IF/ID
//   ex                        : registered ID/EX bundle (decode_stage_if.master)
module decode_stage
   import rv32i_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_id_valid,
   input  logic [31:0]           if_id_pc,
   input  logic [31:0]           if_id_instr,
   input  logic                  flush,
   output logic [4:0]            rs1,
   output logic [4:0]            rs2,
   input  logic [31:0]           rd1,
   input  logic [31:0]           rd2,
   input  logic                  wb_regwrite,
   input  logic [4:0]            wb_rd,
   input  logic [31:0]           wb_wd,
   output logic                  stall,
   decode_stage_if.master        ex
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm;
   logic [31:0] rs1_val, rs2_val;
   ctrl_t       ctrl;
   alu_op_t     alu_op;
   logic        uses_rs1, uses_rs2;
   logic        hazard;

   assign opcode = if_id_instr[6:0];
   assign funct3 = if_id_instr[14:12];
   assign rs1    = if_id_instr[19:15];
   assign rs2    = if_id_instr[24:20];

   imm_gen u_imm_gen (
      .instr (if_id_instr),
      .imm   (imm)
   );

   always_comb begin
      ctrl     = '0;
      alu_op   = ALU_ADD;
      uses_rs1 = 1'b1;
      uses_rs2 = 1'b0;
      case (opcode)
         OP_R: begin
            ctrl.regwrite = 1'b1;
            alu_op        = alu_from_funct3(funct3, if_id_instr[30]);
            uses_rs2      = 1'b1;
         end
         OP_IMM: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            // instr[30] is part of the immediate except for SRAI
            alu_op        = alu_from_funct3(funct3, (funct3 == 3'b101) && if_id_instr[30]);
         end
         OP_LOAD: begin
            ctrl.alusrc   = 1'b1;
            ctrl.memread  = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         OP_STORE: begin
            ctrl.alusrc   = 1'b1;
            ctrl.memwrite = 1'b1;
            uses_rs2      = 1'b1;
         end
         OP_BRANCH: begin
            ctrl.branch   = 1'b1;
            alu_op        = ALU_SUB;
            uses_rs2      = 1'b1;
         end
         OP_JAL: begin
            ctrl.jump     = 1'b1;
            ctrl.regwrite = 1'b1;
            uses_rs1      = 1'b0;
         end
         OP_JALR: begin
            ctrl.alusrc   = 1'b1;
            ctrl.jump     = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         OP_LUI: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            alu_op        = ALU_PASSB;
            uses_rs1      = 1'b0;
         end
         OP_AUIPC: begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            uses_rs1      = 1'b0;
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end

   // Register file commits at the edge, so a same-cycle write must be bypassed.
   assign rs1_val = (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs1)) ? wb_wd : rd1;
   assign rs2_val = (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs2)) ? wb_wd : rd2;

   assign hazard = if_id_valid && ex.id_ex_valid && ex.id_ex_memread && (ex.id_ex_rd != 5'd0) &&
                   ((uses_rs1 && (ex.id_ex_rd == rs1)) || (uses_rs2 && (ex.id_ex_rd == rs2)));

   assign stall = hazard && !flush && !rst;

   // Reset and every bubble share the all-zero register state.
   always_ff @(posedge clk) begin
      if (rst || flush || hazard || !if_id_valid) begin
         ex.id_ex_valid    <= 1'b0;
         ex.id_ex_pc       <= '0;
         ex.id_ex_rs1_val  <= '0;
         ex.id_ex_rs2_val  <= '0;
         ex.id_ex_imm      <= '0;
         ex.id_ex_rs1      <= '0;
         ex.id_ex_rs2      <= '0;
         ex.id_ex_rd       <= '0;
         ex.id_ex_alu_op   <= ALU_ADD;
         ex.id_ex_alusrc   <= 1'b0;
         ex.id_ex_memread  <= 1'b0;
         ex.id_ex_memwrite <= 1'b0;
         ex.id_ex_regwrite <= 1'b0;
         ex.id_ex_memtoreg <= 1'b0;
         ex.id_ex_branch   <= 1'b0;
         ex.id_ex_jump     <= 1'b0;
         ex.id_ex_illegal  <= 1'b0;
         ex.id_ex_funct3   <= '0;
      end else begin
         ex.id_ex_valid    <= 1'b1;
         ex.id_ex_pc       <= if_id_pc;
         ex.id_ex_rs1_val  <= rs1_val;
         ex.id_ex_rs2_val  <= rs2_val;
         ex.id_ex_imm      <= imm;
         ex.id_ex_rs1      <= rs1;
         ex.id_ex_rs2      <= rs2;
         ex.id_ex_rd       <= if_id_instr[11:7];
         ex.id_ex_alu_op   <= alu_op;
         ex.id_ex_alusrc   <= ctrl.alusrc;
         ex.id_ex_memread  <= ctrl.memread;
         ex.id_ex_memwrite <= ctrl.memwrite;
         ex.id_ex_regwrite <= ctrl.regwrite;
         ex.id_ex_memtoreg <= ctrl.memtoreg;
         ex.id_ex_branch   <= ctrl.branch;
         ex.id_ex_jump     <= ctrl.jump;
         ex.id_ex_illegal  <= ctrl.illegal;
         ex.id_ex_funct3   <= funct3;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus randomized check of decode_stage against a
// behavioural reference model of the ID stage and ID/EX register.
module tb_decode_stage;
   import rv32i_pkg::*;

   logic        clk = 1'b0;
   logic        rst, if_id_valid, flush, wb_regwrite;
   logic [31:0] if_id_pc, if_id_instr, rd1, rd2, wb_wd;
   logic [4:0]  wb_rd, rs1, rs2;
   logic        stall;

   decode_stage_if ex_bus ();

   decode_stage dut (
      .clk         (clk),
      .rst         (rst),
      .if_id_valid (if_id_valid),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr),
      .flush       (flush),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd1         (rd1),
      .rd2         (rd2),
      .wb_regwrite (wb_regwrite),
      .wb_rd       (wb_rd),
      .wb_wd       (wb_wd),
      .stall       (stall),
      .ex          (ex_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] pc, v1, v2, imm;
      logic [4:0]  rs1, rs2, rd;
      alu_op_t     alu;
      logic [2:0]  f3;
      logic        alusrc, memread, memwrite, regwrite, memtoreg, branch, jump, illegal;
   } exp_t;

   exp_t        m;            // expected ID/EX contents
   logic        seen_stall;   // stall observed in the most recent step
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t zero_exp();
      exp_t z;
      z.valid = 0; z.pc = 0; z.v1 = 0; z.v2 = 0; z.imm = 0;
      z.rs1 = 0; z.rs2 = 0; z.rd = 0; z.alu = ALU_ADD; z.f3 = 0;
      z.alusrc = 0; z.memread = 0; z.memwrite = 0; z.regwrite = 0;
      z.memtoreg = 0; z.branch = 0; z.jump = 0; z.illegal = 0;
      return z;
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] i);
      logic [31:0] s;
      s = i[31] ? 32'hFFFF_FFFF : 32'h0;
      case (i[6:0])
         7'h13, 7'h03, 7'h67: return $unsigned($signed(i) >>> 20);
         7'h23: return (s << 11) | (32'(i[30:25]) << 5) | 32'(i[11:7]);
         7'h63: return (s << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
         7'h37, 7'h17: return i & 32'hFFFF_F000;
         7'h6F: return (s << 20) | (i & 32'h000F_F000) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
         default: return 32'h0;
      endcase
   endfunction

   function automatic alu_op_t ref_alu(input logic [2:0] f3, input logic alt);
      alu_op_t tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      if (alt && f3 == 3'd0) return ALU_SUB;
      if (alt && f3 == 3'd5) return ALU_SRA;
      return tbl[f3];
   endfunction

   task automatic compare_all();
      check("valid",    ex_bus.id_ex_valid,    m.valid);
      check("pc",       ex_bus.id_ex_pc,       m.pc);
      check("rs1_val",  ex_bus.id_ex_rs1_val,  m.v1);
      check("rs2_val",  ex_bus.id_ex_rs2_val,  m.v2);
      check("imm",      ex_bus.id_ex_imm,      m.imm);
      check("id_rs1",   ex_bus.id_ex_rs1,      m.rs1);
      check("id_rs2",   ex_bus.id_ex_rs2,      m.rs2);
      check("rd",       ex_bus.id_ex_rd,       m.rd);
      check("alu_op",   ex_bus.id_ex_alu_op,   m.alu);
      check("funct3",   ex_bus.id_ex_funct3,   m.f3);
      check("alusrc",   ex_bus.id_ex_alusrc,   m.alusrc);
      check("memread",  ex_bus.id_ex_memread,  m.memread);
      check("memwrite", ex_bus.id_ex_memwrite, m.memwrite);
      check("regwrite", ex_bus.id_ex_regwrite, m.regwrite);
      check("memtoreg", ex_bus.id_ex_memtoreg, m.memtoreg);
      check("branch",   ex_bus.id_ex_branch,   m.branch);
      check("jump",     ex_bus.id_ex_jump,     m.jump);
      check("illegal",  ex_bus.id_ex_illegal,  m.illegal);
   endtask

   // One clock: check combinational outputs mid-cycle, then the registered result.
   task automatic step();
      exp_t        nx;
      logic [31:0] i;
      logic [4:0]  a1, a2;
      logic        use1, use2, haz, estall;
      @(negedge clk);
      i  = if_id_instr;
      a1 = i[19:15];
      a2 = i[24:20];
      nx = zero_exp();
      nx.valid = 1; nx.pc = if_id_pc; nx.imm = ref_imm(i);
      nx.rs1 = a1; nx.rs2 = a2; nx.rd = i[11:7]; nx.f3 = i[14:12];
      nx.v1 = (wb_regwrite && wb_rd != 0 && wb_rd == a1) ? wb_wd : rd1;
      nx.v2 = (wb_regwrite && wb_rd != 0 && wb_rd == a2) ? wb_wd : rd2;
      use1 = 1; use2 = 0;
      case (i[6:0])
         7'h33: begin nx.regwrite = 1; nx.alu = ref_alu(i[14:12], i[30]); use2 = 1; end
         7'h13: begin nx.alusrc = 1; nx.regwrite = 1; nx.alu = ref_alu(i[14:12], i[30] && i[14:12] == 3'd5); end
         7'h03: begin nx.alusrc = 1; nx.memread = 1; nx.regwrite = 1; nx.memtoreg = 1; end
         7'h23: begin nx.alusrc = 1; nx.memwrite = 1; use2 = 1; end
         7'h63: begin nx.branch = 1; nx.alu = ALU_SUB; use2 = 1; end
         7'h6F: begin nx.jump = 1; nx.regwrite = 1; use1 = 0; end
         7'h67: begin nx.alusrc = 1; nx.jump = 1; nx.regwrite = 1; end
         7'h37: begin nx.alusrc = 1; nx.regwrite = 1; nx.alu = ALU_PASSB; use1 = 0; end
         7'h17: begin nx.alusrc = 1; nx.regwrite = 1; use1 = 0; end
         default: nx.illegal = 1;
      endcase
      haz = if_id_valid && m.valid && m.memread && m.rd != 0 &&
            ((use1 && m.rd == a1) || (use2 && m.rd == a2));
      estall = haz && !flush && !rst;
      check("rs1_addr", rs1, a1);
      check("rs2_addr", rs2, a2);
      check("stall", stall, estall);
      seen_stall = stall;
      if (rst || flush || haz || !if_id_valid) nx = zero_exp();
      @(posedge clk);
      #1;
      m = nx;
      compare_all();
   endtask

   task automatic drive(input logic [31:0] instr);
      if_id_instr = instr;
      if_id_valid = 1'b1;
      if_id_pc    = $urandom & 32'hFFFF_FFFC;
      rd1         = $urandom;
      rd2         = $urandom;
      flush       = 1'b0;
      rst         = 1'b0;
      wb_regwrite = 1'b0;
      wb_rd       = 5'd0;
      wb_wd       = 32'h0;
   endtask

   localparam logic [31:0] I_ADDI  = 32'hFFD0_0293; // addi x5,x0,-3
   localparam logic [31:0] I_ADD76 = 32'h0003_03B3; // add x7,x6,x0
   localparam logic [31:0] I_LW    = 32'h0000_A203; // lw x4,0(x1)
   localparam logic [31:0] I_ADD84 = 32'h0022_0433; // add x8,x4,x2
   localparam logic [31:0] I_LUI   = 32'hDEAD_B237; // lui x4,0xDEADB
   localparam logic [31:0] I_SW    = 32'hFE51_2E23; // sw imm -4
   localparam logic [31:0] I_BEQ   = 32'hFE20_8CE3; // beq x1,x2,-8
   localparam logic [31:0] I_JAL   = 32'h0010_00EF; // jal x1,+2048
   localparam logic [31:0] I_ILL   = 32'h0000_027F; // opcode 0x7F

   initial begin
      logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
      logic [31:0] r;

      m = zero_exp();
      drive(32'h0);
      rst = 1'b1;
      step();
      check("rst_valid", ex_bus.id_ex_valid, 0);
      check("rst_seen_stall", seen_stall, 0);

      // basic decode
      drive(I_ADDI); step();
      check("addi_imm", ex_bus.id_ex_imm, 32'hFFFF_FFFD);
      check("addi_alusrc", ex_bus.id_ex_alusrc, 1);
      check("addi_regwrite", ex_bus.id_ex_regwrite, 1);
      check("addi_rd", ex_bus.id_ex_rd, 5);
      check("addi_alu", ex_bus.id_ex_alu_op, ALU_ADD);

      // write-through bypass and its x0 negative case
      drive(I_ADD76); wb_regwrite = 1; wb_rd = 6; wb_wd = 32'hA456_2D47; rd1 = 0; step();
      check("bypass_rs1", ex_bus.id_ex_rs1_val, 32'hA456_2D47);
      drive(I_ADD76); wb_regwrite = 1; wb_rd = 0; wb_wd = 32'hA456_2D47; rd1 = 32'h1357_9BDF; step();
      check("bypass_x0", ex_bus.id_ex_rs1_val, 32'h1357_9BDF);

      // load-use: one stall cycle, then the held add issues
      drive(I_LW); step();
      drive(I_ADD84); step();
      check("lu_stall", seen_stall, 1);
      check("lu_bubble", ex_bus.id_ex_valid, 0);
      step();
      check("lu_release", seen_stall, 0);
      check("lu_issue", ex_bus.id_ex_valid, 1);
      check("lu_issue_rd", ex_bus.id_ex_rd, 8);

      // load followed by lui: no dependency
      drive(I_LW); step();
      drive(I_LUI); step();
      check("nolu_stall", seen_stall, 0);
      check("nolu_valid", ex_bus.id_ex_valid, 1);
      check("lui_imm", ex_bus.id_ex_imm, 32'hDEAD_B000);

      // flush beats stall
      drive(I_LW); step();
      drive(I_ADD84); flush = 1; step();
      check("fl_stall", seen_stall, 0);
      check("fl_valid", ex_bus.id_ex_valid, 0);
      check("fl_regwrite", ex_bus.id_ex_regwrite, 0);

      // immediate formats
      drive(I_SW); step();
      check("sw_imm", ex_bus.id_ex_imm, 32'hFFFF_FFFC);
      drive(I_BEQ); step();
      check("beq_imm", ex_bus.id_ex_imm, 32'hFFFF_FFF8);
      check("beq_branch", ex_bus.id_ex_branch, 1);
      check("beq_alu", ex_bus.id_ex_alu_op, ALU_SUB);
      drive(I_JAL); step();
      check("jal_imm", ex_bus.id_ex_imm, 32'h0000_0800);
      check("jal_jump", ex_bus.id_ex_jump, 1);

      // reset during a stall
      drive(I_LW); step();
      drive(I_ADD84); rst = 1; step();
      check("rstst_stall", seen_stall, 0);
      check("rstst_valid", ex_bus.id_ex_valid, 0);
      check("rstst_pc", ex_bus.id_ex_pc, 0);
      check("rstst_memread", ex_bus.id_ex_memread, 0);

      // illegal opcode
      drive(I_ILL); step();
      check("ill_flag", ex_bus.id_ex_illegal, 1);
      check("ill_regwrite", ex_bus.id_ex_regwrite, 0);
      check("ill_alusrc", ex_bus.id_ex_alusrc, 0);
      check("ill_jump", ex_bus.id_ex_jump, 0);

      // randomized traffic with small register indices to provoke hazards
      for (int k = 0; k < 500; k++) begin
         r = $urandom;
         r[6:0]   = ops[$urandom_range(0, 9)];
         r[11:7]  = 5'($urandom_range(0, 7));
         r[19:15] = 5'($urandom_range(0, 7));
         r[24:20] = 5'($urandom_range(0, 7));
         drive(r);
         if_id_valid = ($urandom_range(0, 9) != 0);
         flush       = ($urandom_range(0, 9) == 0);
         rst         = ($urandom_range(0, 49) == 0);
         wb_regwrite = $urandom_range(0, 1);
         wb_rd       = 5'($urandom_range(0, 7));
         wb_wd       = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
